// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit and its prediction queue.
package bru_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_addr;
  } bru_entry_t;

  localparam int ENTRY_W = $bits(bru_entry_t);

  // Next sequential-or-taken PC; the add wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic        taken,
                                          input logic [31:0] target);
    logic [31:0] seq_pc;
    seq_pc = pc + INSTR_BYTES;
    if (taken) begin
      return target;
    end else begin
      return seq_pc;
    end
  endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order queue of fetch-stage predictions awaiting resolution in EXEC.
// Clear takes priority over push/pop so a flush empties the queue in one edge.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ENTRY_W-1:0]     wdata,
  output logic [ENTRY_W-1:0]     rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push && (count_r != CNT_W'(DEPTH));
    pop_ok_s  = pop && (count_r != CNT_W'(0));
  end

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (clr) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued fetch predictions against EXEC outcomes; issues predictor feedback,
// redirect and flush. Optional mispredict counter: define BRU_PERF_COUNTERS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_predict_valid,
  input  logic [31:0] f_predict_addr,
  output logic        f_stall,
  input  logic        x_valid,
  input  logic        x_is_branch,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  output logic        fb_valid,
  output logic [31:0] fb_pc,
  output logic        fb_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
`ifdef BRU_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] mispredict_cnt
`endif
);

  localparam int QCNT_W = $clog2(DEPTH) + 1;

  bru_state_e         state_r;
  bru_state_e         state_nxt_s;
  logic [QCNT_W-1:0]  count_s;
  logic [ENTRY_W-1:0] rdata_s;
  logic [ENTRY_W-1:0] wdata_s;
  bru_entry_t         head_s;
  bru_entry_t         new_s;
  logic               push_s;
  logic               pop_s;
  logic               mispred_s;
  logic [31:0]        pred_next_s;
  logic [31:0]        actual_next_s;

  // Stall is a pure decode of registered queue occupancy and FSM state.
  assign f_stall = (count_s == QCNT_W'(DEPTH)) || (state_r == RECOVER);

  assign head_s  = bru_entry_t'(rdata_s);
  assign wdata_s = ENTRY_W'(new_s);

  // Push/pop qualification, next-PC compare and FSM next state.
  always_comb begin
    new_s.pc         = f_pc;
    new_s.pred_taken = f_predict_valid;
    new_s.pred_addr  = f_predict_addr;
    push_s        = f_valid && !f_stall && (state_r == RUN);
    pop_s         = x_valid && (count_s != QCNT_W'(0)) && (state_r == RUN);
    pred_next_s   = next_pc(head_s.pc, head_s.pred_taken, head_s.pred_addr);
    actual_next_s = next_pc(head_s.pc, x_is_branch && x_taken, x_target);
    mispred_s     = pop_s && (pred_next_s != actual_next_s);
    state_nxt_s   = state_r;
    case (state_r)
      RUN: begin
        if (mispred_s) begin
          state_nxt_s = RECOVER;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RECOVER: state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // A mispredict clears the queue, which also discards any same-cycle push.
  bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mispred_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // One-cycle feedback / redirect strobes; payloads are zero when not strobed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_valid       <= 1'b0;
      fb_pc          <= 32'd0;
      fb_taken       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
    end else begin
      fb_valid       <= pop_s && x_is_branch;
      fb_pc          <= (pop_s && x_is_branch) ? head_s.pc : 32'd0;
      fb_taken       <= pop_s && x_is_branch && x_taken;
      redirect_valid <= mispred_s;
      redirect_pc    <= mispred_s ? actual_next_s : 32'd0;
      flush          <= mispred_s;
    end
  end

`ifdef BRU_PERF_COUNTERS_EN
  // Saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_cnt <= {CNT_W{1'b0}};
    end else if (mispred_s && (mispredict_cnt != {CNT_W{1'b1}})) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end else begin
      mispredict_cnt <= mispredict_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based reference model predicts
// feedback/redirect strobes; a separate monitor pops and compares them.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid, f_predict_valid, f_stall;
  logic [31:0] f_pc, f_predict_addr;
  logic        x_valid, x_is_branch, x_taken;
  logic [31:0] x_target;
  logic        fb_valid, fb_taken, redirect_valid, flush;
  logic [31:0] fb_pc, redirect_pc;
`ifdef BRU_PERF_COUNTERS_EN
  logic [CNT_W-1:0] mispredict_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_predict_valid(f_predict_valid),
    .f_predict_addr (f_predict_addr),
    .f_stall        (f_stall),
    .x_valid        (x_valid),
    .x_is_branch    (x_is_branch),
    .x_taken        (x_taken),
    .x_target       (x_target),
    .fb_valid       (fb_valid),
    .fb_pc          (fb_pc),
    .fb_taken       (fb_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRU_PERF_COUNTERS_EN
    ,
    .mispredict_cnt (mispredict_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pa;
  } ent_t;

  typedef struct {
    int          cyc;
    logic        fb_v;
    logic [31:0] fb_pc;
    logic        fb_t;
    logic        rd_v;
    logic [31:0] rd_pc;
  } exp_t;

  ent_t        mq[$];
  exp_t        eq[$];
  bit          m_recover;
  longint      m_mcnt;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every cycle either a due expectation is compared or no strobe may appear.
  always @(negedge clk) begin
    if (eq.size() > 0 && eq[0].cyc <= cyc) begin
      exp_t e;
      e = eq.pop_front();
      check("fb_valid", {31'd0, fb_valid}, {31'd0, e.fb_v});
      if (e.fb_v) begin
        check("fb_pc", fb_pc, e.fb_pc);
        check("fb_taken", {31'd0, fb_taken}, {31'd0, e.fb_t});
      end
      check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rd_v});
      check("flush", {31'd0, flush}, {31'd0, e.rd_v});
      if (e.rd_v) begin
        check("redirect_pc", redirect_pc, e.rd_pc);
      end
    end else if (fb_valid || redirect_valid || flush) begin
      check("unexpected_strobe", {29'd0, fb_valid, redirect_valid, flush}, 32'd0);
    end
  end

  // One cycle: check stall, drive inputs, advance the reference model, wait a cycle.
  task automatic step(input bit rn, input bit fv, input logic [31:0] fpc, input bit fpt,
                      input logic [31:0] fpa, input bit xv, input bit xb, input bit xt,
                      input logic [31:0] xtg);
    bit          exp_stall, pop, mis;
    ent_t        e;
    logic [31:0] pn, an;
    exp_stall = (mq.size() == DEPTH) || m_recover;
    check("f_stall", {31'd0, f_stall}, {31'd0, exp_stall});
`ifdef BRU_PERF_COUNTERS_EN
    check("mispredict_cnt", {16'd0, mispredict_cnt}, m_mcnt[31:0]);
`endif
    rst_n = rn; f_valid = fv; f_pc = fpc; f_predict_valid = fpt; f_predict_addr = fpa;
    x_valid = xv; x_is_branch = xb; x_taken = xt; x_target = xtg;
    if (!rn) begin
      mq.delete();
      m_recover = 1'b0;
      m_mcnt = 0;
    end else begin
      pop = xv && (mq.size() > 0) && !m_recover;
      mis = 1'b0;
      if (pop) begin
        e  = mq.pop_front();
        pn = e.pt ? e.pa : e.pc + 32'd4;
        an = (xb && xt) ? xtg : e.pc + 32'd4;
        mis = (pn != an);
        if (xb || mis) eq.push_back('{cyc + 1, xb, e.pc, xt, mis, an});
        if (mis) begin
          mq.delete();
          if (m_mcnt < 65535) m_mcnt++;
        end
      end
      if (fv && !exp_stall && !mis) mq.push_back('{fpc, fpt, fpa});
      m_recover = mis;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] pc, input bit pt, input logic [31:0] pa);
    step(1'b1, 1'b1, pc, pt, pa, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input bit xb, input bit xt, input logic [31:0] tg);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, xb, xt, tg);
  endtask

  initial begin
    bit          rn, fv, fpt, xv, xb, xt;
    logic [31:0] fpc, fpa, xtg, r;
    cyc = 0; n_checks = 0; n_fail = 0; m_recover = 1'b0; m_mcnt = 0;
    rst_n = 1'b0; f_valid = 1'b0; f_pc = 32'd0; f_predict_valid = 1'b0; f_predict_addr = 32'd0;
    x_valid = 1'b0; x_is_branch = 1'b0; x_taken = 1'b0; x_target = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_fb_valid", {31'd0, fb_valid}, 32'd0);
    check("rst_fb_pc", fb_pc, 32'd0);
    check("rst_fb_taken", {31'd0, fb_taken}, 32'd0);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_f_stall", {31'd0, f_stall}, 32'd0);

    // Correct taken prediction: feedback only.
    push(32'h40, 1'b1, 32'h80);
    resolve(1'b1, 1'b1, 32'h80);
    idle(2);
    // Predicted not-taken, actually taken: redirect, flush, one RECOVER cycle.
    push(32'h100, 1'b0, 32'h0);
    push(32'h104, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(2);
    // Taken prediction on a non-branch.
    push(32'h10, 1'b1, 32'h50);
    resolve(1'b0, 1'b0, 32'h0);
    idle(2);
    // Fill, then pop+push while full.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    push(32'h2000, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) resolve(1'b1, 1'b0, 32'h0);
    idle(1);
    // PC wrap: both next-PCs are 0.
    push(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h0);
    idle(1);
    // Reset with entries queued, coinciding with a mispredicting pop.
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(i * 4), 1'b1, 32'h900);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("mid_rst_fb_valid", {31'd0, fb_valid}, 32'd0);
    check("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    resolve(1'b1, 1'b1, 32'h900);
    idle(2);

    // Randomized traffic, biased so most resolutions agree with the prediction.
    for (int n = 0; n < 3000; n++) begin
      rn  = ($urandom_range(0, 299) != 0);
      fv  = ($urandom_range(0, 2) != 0);
      r   = $urandom();
      fpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
      fpt = $urandom_range(0, 1);
      fpa = $urandom() & 32'hFFFF_FFFC;
      xv  = ($urandom_range(0, 2) != 0);
      xb  = $urandom_range(0, 1);
      xt  = $urandom_range(0, 1);
      xtg = $urandom() & 32'hFFFF_FFFC;
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
        if (mq[0].pt) begin
          xb = 1'b1; xt = 1'b1; xtg = mq[0].pa;
        end else begin
          xt = 1'b0;
        end
      end
      step(rn, fv, fpc, fpt, fpa, xv, xb, xt, xtg);
    end
    idle(3);
    check("scoreboard_drained", eq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
